// File: rtl/bus_gate_arbiter.sv
// Registered N-source bus gate with fixed-priority / round-robin arbitration and conflict tracking.
// Optional saturating conflict counter enabled by defining BUS_CONFLICT_CNT_EN.
module bus_gate_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned HOLD_LAST = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Mode,
    input  logic [N_SRC-1:0]           Gate,
    input  logic [N_SRC*WIDTH-1:0]     Src_Data,
    input  logic                       Clr_Sticky,
    output logic [WIDTH-1:0]           Data,
    output logic                       Data_Valid,
    output logic [$clog2(N_SRC)-1:0]   Owner,
    output logic                       Conflict,
    output logic                       Conflict_Sticky
`ifdef BUS_CONFLICT_CNT_EN
   ,output logic [CNT_W-1:0]           Conflict_Count
`endif
);

    localparam int unsigned OW = $clog2(N_SRC);

    if (N_SRC < 2 || CNT_W < 1) begin : g_param_check
        $error("bus_gate_arbiter: N_SRC must be >= 2 and CNT_W >= 1");
    end

    logic [OW-1:0]    rr_ptr;
    logic [OW-1:0]    rr_ptr_next;
    logic             grant;
    logic [OW-1:0]    win_idx;
    logic [WIDTH-1:0] win_data;
    logic             conflict_now;
    int unsigned      n_set;

    // Round-robin is two passes: first at/after rr_ptr, then wrap from index 0.
    always_comb begin
        grant   = 1'b0;
        win_idx = '0;
        if (!Mode) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (!grant && Gate[i]) begin
                    grant   = 1'b1;
                    win_idx = OW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (!grant && Gate[i] && (i >= 32'(rr_ptr))) begin
                    grant   = 1'b1;
                    win_idx = OW'(i);
                end
            end
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (!grant && Gate[i]) begin
                    grant   = 1'b1;
                    win_idx = OW'(i);
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (32'(win_idx) == i) begin
                win_data = Src_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        n_set = 0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            n_set = n_set + 32'(Gate[i]);
        end
        conflict_now = (n_set >= 2);
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant && Mode) begin
            rr_ptr_next = (win_idx == OW'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data            <= '0;
            Data_Valid      <= 1'b0;
            Owner           <= '0;
            Conflict        <= 1'b0;
            Conflict_Sticky <= 1'b0;
            rr_ptr          <= '0;
        end else begin
            Conflict <= conflict_now;
            rr_ptr   <= rr_ptr_next;
            if (conflict_now) begin
                Conflict_Sticky <= 1'b1;
            end else if (Clr_Sticky) begin
                Conflict_Sticky <= 1'b0;
            end
            if (grant) begin
                Data       <= win_data;
                Owner      <= win_idx;
                Data_Valid <= 1'b1;
            end else begin
                Data_Valid <= 1'b0;
                if (HOLD_LAST == 0) begin
                    Data <= '0;
                end
            end
        end
    end

`ifdef BUS_CONFLICT_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Conflict_Count <= '0;
        end else if (Clr_Sticky) begin
            Conflict_Count <= conflict_now ? CNT_W'(1) : '0;
        end else if (conflict_now && (Conflict_Count != '1)) begin
            Conflict_Count <= Conflict_Count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed self-checking bench for bus_gate_arbiter (HOLD_LAST=1 and HOLD_LAST=0 instances).
module tb_bus_gate_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mode;
    logic [3:0]  Gate;
    logic [63:0] Src_Data;
    logic        Clr_Sticky;

    logic [15:0] data_h, data_z;
    logic        valid_h, valid_z;
    logic [1:0]  owner_h, owner_z;
    logic        conf_h, conf_z;
    logic        sticky_h, sticky_z;
`ifdef BUS_CONFLICT_CNT_EN
    logic [1:0]  count_h, count_z;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    bus_gate_arbiter #(.WIDTH(16), .N_SRC(4), .HOLD_LAST(1), .CNT_W(2)) u_hold (
        .Clk(Clk), .Reset(Reset), .Mode(Mode), .Gate(Gate), .Src_Data(Src_Data),
        .Clr_Sticky(Clr_Sticky), .Data(data_h), .Data_Valid(valid_h), .Owner(owner_h),
        .Conflict(conf_h), .Conflict_Sticky(sticky_h)
`ifdef BUS_CONFLICT_CNT_EN
       ,.Conflict_Count(count_h)
`endif
    );

    bus_gate_arbiter #(.WIDTH(16), .N_SRC(4), .HOLD_LAST(0), .CNT_W(2)) u_zero (
        .Clk(Clk), .Reset(Reset), .Mode(Mode), .Gate(Gate), .Src_Data(Src_Data),
        .Clr_Sticky(Clr_Sticky), .Data(data_z), .Data_Valid(valid_z), .Owner(owner_z),
        .Conflict(conf_z), .Conflict_Sticky(sticky_z)
`ifdef BUS_CONFLICT_CNT_EN
       ,.Conflict_Count(count_z)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] own, input logic [15:0] dat,
                             input logic conf);
        chk({tag, ".owner"}, 32'(owner_h), 32'(own));
        chk({tag, ".data"}, 32'(data_h), 32'(dat));
        chk({tag, ".valid"}, 32'(valid_h), 32'd1);
        chk({tag, ".conflict"}, 32'(conf_h), 32'(conf));
    endtask

    initial begin
        Reset      = 1'b1;
        Mode       = 1'b0;
        Gate       = 4'b0000;
        Clr_Sticky = 1'b0;
        Src_Data   = {16'h00AA, 16'hBEEF, 16'h1234, 16'h1111};
        tick();
        chk("rst.data", 32'(data_h), 32'h0);
        chk("rst.valid", 32'(valid_h), 32'h0);
        chk("rst.owner", 32'(owner_h), 32'h0);
        chk("rst.conflict", 32'(conf_h), 32'h0);
        chk("rst.sticky", 32'(sticky_h), 32'h0);

        // Fixed priority, conflict between sources 1 and 2
        Reset = 1'b0;
        Gate  = 4'b0110;
        tick();
        chk_grant("fixed0110", 2'd1, 16'h1234, 1'b1);
        chk("fixed0110.sticky", 32'(sticky_h), 32'd1);

        // Sticky clear race: set wins, then clear takes effect
        Clr_Sticky = 1'b1;
        Gate       = 4'b0011;
        tick();
        chk_grant("race", 2'd0, 16'h1111, 1'b1);
        chk("race.sticky", 32'(sticky_h), 32'd1);
        Gate = 4'b0001;
        tick();
        chk_grant("clear", 2'd0, 16'h1111, 1'b0);
        chk("clear.sticky", 32'(sticky_h), 32'd0);

        // Idle hold after a grant from source 3
        Clr_Sticky = 1'b0;
        Gate       = 4'b1000;
        tick();
        chk_grant("grant3", 2'd3, 16'h00AA, 1'b0);
        chk("grant3.zdata", 32'(data_z), 32'h00AA);
        Gate = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle.data_hold", 32'(data_h), 32'h00AA);
            chk("idle.data_zero", 32'(data_z), 32'h0000);
            chk("idle.valid", 32'(valid_h), 32'd0);
            chk("idle.owner", 32'(owner_h), 32'd3);
            chk("idle.zvalid", 32'(valid_z), 32'd0);
            chk("idle.zowner", 32'(owner_z), 32'd3);
        end

        Gate = 4'b1100;
        tick();
        chk_grant("fixed1100", 2'd2, 16'hBEEF, 1'b1);

        // Round-robin fairness from a fresh reset
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Mode  = 1'b1;
        Gate  = 4'b1111;
        tick(); chk_grant("rr1", 2'd0, 16'h1111, 1'b1);
        tick(); chk_grant("rr2", 2'd1, 16'h1234, 1'b1);
        tick(); chk_grant("rr3", 2'd2, 16'hBEEF, 1'b1);
        tick(); chk_grant("rr4", 2'd3, 16'h00AA, 1'b1);
        tick(); chk_grant("rr5", 2'd0, 16'h1111, 1'b1);

        // rr_ptr=1: wrap search, then ptr advance past 3 back to 0
        Gate = 4'b0001;
        tick(); chk_grant("rrwrap", 2'd0, 16'h1111, 1'b0);
        Gate = 4'b1001;
        tick(); chk_grant("rr1001a", 2'd3, 16'h00AA, 1'b1);
        tick(); chk_grant("rr1001b", 2'd0, 16'h1111, 1'b1);

        // Mode switch: fixed ignores rr_ptr(=1) and leaves it alone
        Mode = 1'b0;
        Gate = 4'b1001;
        tick(); chk_grant("sw.fixed", 2'd0, 16'h1111, 1'b1);
        Mode = 1'b1;
        Gate = 4'b0101;
        tick(); chk_grant("sw.rr", 2'd2, 16'hBEEF, 1'b1);
        Gate = 4'b0110;
        tick(); chk_grant("rrptr3", 2'd1, 16'h1234, 1'b1);
        Gate = 4'b0110;
        tick(); chk_grant("rrptr2", 2'd2, 16'hBEEF, 1'b1);

        // Reset during a conflict cycle, rr_ptr is 3 here
        Gate  = 4'b1100;
        Reset = 1'b1;
        tick();
        chk("rstmid.data", 32'(data_h), 32'h0);
        chk("rstmid.valid", 32'(valid_h), 32'h0);
        chk("rstmid.owner", 32'(owner_h), 32'h0);
        chk("rstmid.conflict", 32'(conf_h), 32'h0);
        chk("rstmid.sticky", 32'(sticky_h), 32'h0);
        Reset = 1'b0;
        Gate  = 4'b1111;
        tick(); chk_grant("rstmid.after", 2'd0, 16'h1111, 1'b1);

`ifdef BUS_CONFLICT_CNT_EN
        Clr_Sticky = 1'b1;
        Gate       = 4'b0000;
        tick();
        chk("cnt.clr0", 32'(count_h), 32'd0);
        Clr_Sticky = 1'b0;
        Gate       = 4'b1111;
        tick(); chk("cnt.c1", 32'(count_h), 32'd1);
        tick(); chk("cnt.c2", 32'(count_h), 32'd2);
        tick(); chk("cnt.c3", 32'(count_h), 32'd3);
        tick(); chk("cnt.sat4", 32'(count_h), 32'd3);
        tick(); chk("cnt.sat5", 32'(count_h), 32'd3);
        Clr_Sticky = 1'b1;
        Gate       = 4'b0000;
        tick(); chk("cnt.clr", 32'(count_h), 32'd0);
        Gate = 4'b0011;
        tick(); chk("cnt.clr_conf", 32'(count_h), 32'd1);
        Clr_Sticky = 1'b0;
        Gate       = 4'b0000;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
